// File: rtl/main_memory_resp.sv
// main_memory_resp: block-granular main-memory responder at the memory end of
// the cache<->memory interface. It serves line fills (reads) and dirty-line
// write-backs (writes) with fixed latencies, one request at a time.
// A write and a read sampled together commit the write first, then read.
// Every line starts as zero at time 0; INIT_FILE is kept as a parameter only.
module main_memory_resp #(
    parameter int PA_WIDTH   = 32,
    parameter int BLK_WIDTH  = 512,
    parameter int MEM_BLOCKS = 1024,
    parameter int RD_LATENCY = 4,
    parameter int WR_LATENCY = 4,
    parameter     INIT_FILE  = "mem_init.hex"
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PA_WIDTH-1:0]  mem_addr,
    input  logic [PA_WIDTH-1:0]  mem_wr_addr,
    input  logic                 mem_rd_en,
    input  logic                 mem_wr_en,
    input  logic [BLK_WIDTH-1:0] mem_wr_blk,
    output logic [BLK_WIDTH-1:0] mem_rd_blk,
    output logic                 mem_rd_valid,
    output logic                 mem_wr_done,
    output logic                 mem_busy
);
    localparam int OFF     = $clog2(BLK_WIDTH / 8);
    localparam int IDX     = $clog2(MEM_BLOCKS);
    localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2
    } state_t;

    state_t               state_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [IDX-1:0]       rd_idx_reg;
    logic [IDX-1:0]       wr_idx_reg;
    logic [BLK_WIDTH-1:0] wr_blk_reg;
    logic                 rd_pend_reg;
    logic [BLK_WIDTH-1:0] rd_blk_reg;
    logic                 rd_valid_reg;
    logic                 wr_done_reg;
    logic                 busy_reg;

    // Line storage: zero at time 0.
    logic [BLK_WIDTH-1:0] mem_array [MEM_BLOCKS] = '{default: '0};

    // Offset bits and the bits above the index are dropped, so addresses alias.
    function automatic logic [IDX-1:0] line_idx(input logic [PA_WIDTH-1:0] addr);
        return addr[OFF +: IDX];
    endfunction

    logic                 accept;
    logic                 wr_fire;
    logic                 rd_fire;
    logic [IDX-1:0]       wr_idx_sel;
    logic [IDX-1:0]       rd_idx_sel;
    logic [BLK_WIDTH-1:0] wr_blk_sel;

    // A request is taken only in IDLE; the acceptance edge is the first
    // latency cycle, so a latency of 1 fires directly at that edge using the
    // live inputs, and every later fire uses the latched copies.
    always_comb begin
        accept     = (state_reg == S_IDLE) && (mem_rd_en || mem_wr_en);
        wr_idx_sel = (state_reg == S_IDLE) ? line_idx(mem_wr_addr) : wr_idx_reg;
        rd_idx_sel = (state_reg == S_IDLE) ? line_idx(mem_addr)    : rd_idx_reg;
        wr_blk_sel = (state_reg == S_IDLE) ? mem_wr_blk            : wr_blk_reg;
        wr_fire    = ((state_reg == S_WRITE) && (cnt_reg == WR_LAST)) ||
                     (accept && mem_wr_en && (WR_LATENCY == 1));
        rd_fire    = ((state_reg == S_READ) && (cnt_reg == RD_LAST)) ||
                     (accept && mem_rd_en && !mem_wr_en && (RD_LATENCY == 1));
    end

    // Array write port: commit a write-back in the same cycle its done pulse is raised.
    always_ff @(posedge clk) begin
        if (!rst && wr_fire) begin
            mem_array[wr_idx_sel] <= wr_blk_sel;
        end
    end

    // Registered read port: fill data is loaded with the valid pulse and held until the next fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_blk_reg <= '0;
        end else if (rd_fire) begin
            rd_blk_reg <= mem_array[rd_idx_sel];
        end
    end

    // Control FSM with latency counter, request latches and registered pulses/busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            rd_idx_reg   <= '0;
            wr_idx_reg   <= '0;
            wr_blk_reg   <= '0;
            rd_pend_reg  <= 1'b0;
            rd_valid_reg <= 1'b0;
            wr_done_reg  <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            rd_valid_reg <= rd_fire;
            wr_done_reg  <= wr_fire;
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        rd_idx_reg  <= line_idx(mem_addr);
                        wr_idx_reg  <= line_idx(mem_wr_addr);
                        wr_blk_reg  <= mem_wr_blk;
                        rd_pend_reg <= mem_rd_en;
                        cnt_reg     <= CNT_ONE;
                        if (mem_wr_en) begin
                            if (WR_LATENCY != 1) begin
                                state_reg <= S_WRITE;
                                busy_reg  <= 1'b1;
                            end else if (mem_rd_en) begin
                                // Write already committed this edge; read phase starts now.
                                state_reg <= S_READ;
                                cnt_reg   <= '0;
                                busy_reg  <= 1'b1;
                            end
                        end else if (RD_LATENCY != 1) begin
                            state_reg <= S_READ;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (cnt_reg == WR_LAST) begin
                        if (rd_pend_reg) begin
                            state_reg <= S_READ;
                            cnt_reg   <= '0;
                        end else begin
                            state_reg <= S_IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                S_READ: begin
                    if (cnt_reg == RD_LAST) begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rd_blk   = rd_blk_reg;
    assign mem_rd_valid = rd_valid_reg;
    assign mem_wr_done  = wr_done_reg;
    assign mem_busy     = busy_reg;

endmodule

// File: tb/tb_main_memory_resp.sv
// Testbench for main_memory_resp: directed scenarios followed by randomized
// traffic. A reference model of the memory (array keyed by line number)
// predicts every pulse cycle and fill value; a monitor compares them.
module tb_main_memory_resp;
    localparam int BW = 512;
    localparam int NB = 1024;
    localparam int RL = 4;
    localparam int WL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   mem_addr = '0;
    logic [31:0]   mem_wr_addr = '0;
    logic          mem_rd_en = 1'b0;
    logic          mem_wr_en = 1'b0;
    logic [BW-1:0] mem_wr_blk = '0;
    logic [BW-1:0] mem_rd_blk;
    logic          mem_rd_valid;
    logic          mem_wr_done;
    logic          mem_busy;

    main_memory_resp #(
        .PA_WIDTH(32), .BLK_WIDTH(BW), .MEM_BLOCKS(NB),
        .RD_LATENCY(RL), .WR_LATENCY(WL)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_wr_addr(mem_wr_addr),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_wr_blk(mem_wr_blk), .mem_rd_blk(mem_rd_blk),
        .mem_rd_valid(mem_rd_valid), .mem_wr_done(mem_wr_done),
        .mem_busy(mem_busy)
    );

    always #5 clk = ~clk;

    // Number of rising edges so far; at a falling edge the next edge is edge_cnt+1.
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int            cyc;
        bit            is_rd;
        int            idx;
        logic [BW-1:0] data;
        logic [BW-1:0] old;
    } ev_t;

    ev_t           sb[$];
    logic [BW-1:0] mdl [int];
    bit            rst_at [int];
    int            free_at = 0;
    int            busy_lo = 1;
    int            busy_hi = 0;
    int            tests = 0;
    int            fails = 0;
    bit            mon_en = 1'b0;
    logic [BW-1:0] hold = '0;

    function automatic int line_of(input logic [31:0] a);
        return int'((a / 32'd64) % NB);
    endfunction

    function automatic logic [BW-1:0] mdl_rd(input int idx);
        if (mdl.exists(idx)) return mdl[idx];
        return '0;
    endfunction

    function automatic logic [BW-1:0] rand_blk();
        logic [BW-1:0] b;
        for (int i = 0; i < BW / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // One cycle of stimulus: drive inputs for the next edge and update the model.
    task automatic step(input bit r, input bit rd, input bit wr,
                        input logic [31:0] ra, input logic [31:0] wa,
                        input logic [BW-1:0] blk, output bit acc);
        int  n;
        int  last;
        ev_t e;
        ev_t keep[$];
        @(negedge clk);
        n = edge_cnt + 1;
        rst = r; mem_rd_en = rd; mem_wr_en = wr;
        mem_addr = ra; mem_wr_addr = wa; mem_wr_blk = blk;
        acc = 1'b0;
        if (r) begin
            // Pulses set before this edge survive; later ones (and uncommitted writes) are lost.
            rst_at[n] = 1'b1;
            keep = {};
            foreach (sb[i]) begin
                if (sb[i].cyc <= n) keep.push_back(sb[i]);
                else if (!sb[i].is_rd) mdl[sb[i].idx] = sb[i].old;
            end
            sb = keep;
            if (busy_hi > n) busy_hi = n;
            free_at = n + 1;
        end else if ((rd || wr) && n >= free_at) begin
            acc = 1'b1;
            last = n;
            if (wr) begin
                e.cyc = n + WL; e.is_rd = 1'b0; e.idx = line_of(wa);
                e.old = mdl_rd(e.idx); e.data = blk;
                mdl[e.idx] = blk;
                sb.push_back(e);
                last = e.cyc;
            end
            if (rd) begin
                e.cyc = wr ? n + WL + RL : n + RL; e.is_rd = 1'b1;
                e.idx = line_of(ra); e.data = mdl_rd(e.idx); e.old = '0;
                sb.push_back(e);
                last = e.cyc;
            end
            free_at = last;
            busy_lo = n + 1;
            busy_hi = last - 1;
        end
    endtask

    // Hold a request until the responder takes it.
    task automatic req(input bit rd, input bit wr, input logic [31:0] ra,
                       input logic [31:0] wa, input logic [BW-1:0] blk);
        bit acc;
        for (int k = 0; k < 100; k++) begin
            step(1'b0, rd, wr, ra, wa, blk, acc);
            if (acc) break;
        end
    endtask

    task automatic idle(input int k);
        bit acc;
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0, '0, '0, '0, acc);
    endtask

    // Monitor: compare pulses, fill data, busy and held fill data every cycle.
    int  mon_n;
    ev_t mon_e;
    bit  exp_busy;
    initial begin
        forever begin
            @(negedge clk);
            mon_n = edge_cnt + 1;
            if (mon_en) begin
                if (rst_at.exists(mon_n - 1)) hold = '0;
                while (sb.size() > 0 && sb[0].cyc < mon_n) begin
                    mon_e = sb.pop_front();
                    tests++; fails++;
                    $display("FAIL missed_pulse is_rd=%0d got=none required_cycle=%0d", mon_e.is_rd, mon_e.cyc);
                end
                if (mem_rd_valid || mem_wr_done) begin
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_pulse cyc=%0d got rd_valid=%0b wr_done=%0b required none",
                                 mon_n, mem_rd_valid, mem_wr_done);
                    end else begin
                        mon_e = sb.pop_front();
                        if (mon_e.cyc != mon_n || mem_rd_valid != mon_e.is_rd || mem_wr_done != !mon_e.is_rd) begin
                            fails++;
                            $display("FAIL pulse_timing got cyc=%0d rd_valid=%0b wr_done=%0b required cyc=%0d is_rd=%0d",
                                     mon_n, mem_rd_valid, mem_wr_done, mon_e.cyc, mon_e.is_rd);
                        end
                        if (mon_e.is_rd) hold = mon_e.data;
                        $display("[TB] cyc=%0d %s line=%0d data[31:0]=%h", mon_n,
                                 mon_e.is_rd ? "read " : "write", mon_e.idx, mon_e.data[31:0]);
                    end
                end
                exp_busy = (mon_n >= busy_lo) && (mon_n <= busy_hi);
                tests++;
                if (mem_busy !== exp_busy) begin
                    fails++;
                    $display("FAIL busy cyc=%0d got=%b required=%b", mon_n, mem_busy, exp_busy);
                end
                tests++;
                if (mem_rd_blk !== hold) begin
                    fails++;
                    $display("FAIL rd_blk cyc=%0d got=%h required=%h", mon_n, mem_rd_blk, hold);
                end
            end
        end
    end

    // Stimulus: directed scenarios, then random traffic with occasional resets.
    initial begin
        bit            acc;
        bit            r;
        bit            rd;
        bit            wr;
        logic [31:0]   ra;
        logic [31:0]   wa;
        logic [BW-1:0] blk_b;
        blk_b = rand_blk();

        step(1'b1, 1'b0, 1'b0, '0, '0, '0, acc);
        step(1'b1, 1'b0, 1'b0, '0, '0, '0, acc);
        mon_en = 1'b1;

        // Fill of a never-written line returns zeros.
        req(1'b1, 1'b0, 32'h0000_0040, '0, '0);
        // Write-back then fill of the same line.
        req(1'b0, 1'b1, '0, 32'h0000_1000, {16{32'hA5A5_A5A5}});
        req(1'b1, 1'b0, 32'h0000_1000, '0, '0);
        // Combined write + read of the same line: read sees new data.
        req(1'b1, 1'b1, 32'h0000_0080, 32'h0000_0080, blk_b);
        idle(10);
        // Aliasing above the index and within the offset.
        req(1'b0, 1'b1, '0, 32'h0001_0000, {16{32'hC3C3_0C0C}});
        req(1'b1, 1'b0, 32'h0000_0000, '0, '0);
        req(1'b1, 1'b0, 32'h0000_003C, '0, '0);
        // Reset two cycles into a write drops it.
        req(1'b0, 1'b1, '0, 32'h0000_0200, {16{32'hD00D_D00D}});
        req(1'b0, 1'b1, '0, 32'h0000_0200, {16{32'hEEEE_1111}});
        idle(1);
        step(1'b1, 1'b0, 1'b0, '0, '0, '0, acc);
        idle(2);
        req(1'b1, 1'b0, 32'h0000_0200, '0, '0);
        // Requests while busy are ignored; held request is accepted back-to-back.
        idle(6);
        req(1'b1, 1'b0, 32'h0000_0080, '0, '0);
        idle(1);
        step(1'b0, 1'b1, 1'b0, 32'h0000_1000, '0, '0, acc);
        req(1'b1, 1'b0, 32'h0000_1000, '0, '0);

        for (int i = 0; i < 1500; i++) begin
            r  = ($urandom_range(0, 79) == 0);
            rd = ($urandom_range(0, 1) == 1);
            wr = ($urandom_range(0, 2) == 0);
            ra = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 7)) << 6) | 32'($urandom_range(0, 63));
            wa = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 7)) << 6) | 32'($urandom_range(0, 63));
            step(r, rd, wr, ra, wa, rand_blk(), acc);
        end

        idle(20);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain got=%0d outstanding required=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
